// File: rtl/tdm_demux_4to1_if.sv
// Bundle of the serial word stream and the demultiplexed/status outputs.
// No latency of its own; it only carries signals between the source and the demux.
// No backpressure: the source advances whenever In_valid is high.
interface tdm_demux_4to1_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0]   In;
  logic               In_valid;
  logic               Sync;
  logic [4*WIDTH-1:0] Out;
  logic [3:0]         Out_valid;
  logic [4*WIDTH-1:0] Frame;
  logic               Frame_valid;
  logic               Locked;
  logic               Sync_err;
  logic [ERR_W-1:0]   Err_cnt;

  // Word source side.
  modport master (
    output In, In_valid, Sync,
    input  Out, Out_valid, Frame, Frame_valid, Locked, Sync_err, Err_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  In, In_valid, Sync,
    output Out, Out_valid, Frame, Frame_valid, Locked, Sync_err, Err_cnt
  );
endinterface

// File: rtl/tdm_demux_4to1.sv
// 1-to-4 TDM demux: routes each word to its channel, snapshots full frames, tracks alignment.
// Latency: one clock from accepted word to Out/Out_valid and from slot-3 word to Frame_valid.
// No backpressure: every In_valid word is consumed; gaps simply hold all state.
module tdm_demux_4to1 #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  tdm_demux_4to1_if.slave  bus
);
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t             state, state_nxt;
  logic [1:0]         slot, slot_nxt;
  logic               wr_en;
  logic [1:0]         wr_slot;
  logic               frame_done;
  logic               err;

  logic [4*WIDTH-1:0] fbuf, fbuf_nxt;
  logic [4*WIDTH-1:0] out_q, out_nxt;
  logic [3:0]         out_vld_q;
  logic [4*WIDTH-1:0] frame_q;
  logic               frame_vld_q;
  logic               sync_err_q;
  logic [ERR_W-1:0]   err_cnt_q;

  // Alignment state and expected slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= 2'd0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Decide per accepted word: where it goes, whether it closes a frame, whether it is an error.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    wr_en      = 1'b0;
    wr_slot    = 2'd0;
    frame_done = 1'b0;
    err        = 1'b0;
    if (bus.In_valid) begin
      case (state)
        HUNT: begin
          // Only a marked word can start alignment; everything else is dropped quietly.
          if (bus.Sync) begin
            state_nxt = LOCK;
            wr_en     = 1'b1;
            slot_nxt  = 2'd1;
          end
        end
        LOCK: begin
          if (bus.Sync) begin
            // A marker always restarts the frame; early ones abandon the partial frame.
            err      = (slot != 2'd0);
            wr_en    = 1'b1;
            slot_nxt = 2'd1;
          end else if (slot == 2'd0) begin
            // Expected a marker and none came: alignment lost, word dropped.
            err       = 1'b1;
            state_nxt = HUNT;
          end else begin
            wr_en      = 1'b1;
            wr_slot    = slot;
            slot_nxt   = slot + 2'd1;
            frame_done = (slot == 2'd3);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Buffer and channel images with the current word merged in, so slot 3 can go straight into Frame.
  always_comb begin
    fbuf_nxt = fbuf;
    out_nxt  = out_q;
    if (wr_en) begin
      fbuf_nxt[wr_slot*WIDTH +: WIDTH] = bus.In;
      out_nxt[wr_slot*WIDTH +: WIDTH]  = bus.In;
    end
  end

  // Output registers, pulses and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbuf        <= '0;
      out_q       <= '0;
      out_vld_q   <= 4'b0000;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      fbuf        <= fbuf_nxt;
      out_q       <= out_nxt;
      out_vld_q   <= 4'b0000;
      frame_vld_q <= frame_done;
      sync_err_q  <= err;
      if (wr_en) begin
        out_vld_q[wr_slot] <= 1'b1;
      end
      if (frame_done) begin
        frame_q <= fbuf_nxt;
      end
      if (err && (err_cnt_q != ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.Out         = out_q;
  assign bus.Out_valid   = out_vld_q;
  assign bus.Frame       = frame_q;
  assign bus.Frame_valid = frame_vld_q;
  assign bus.Locked      = (state == LOCK);
  assign bus.Sync_err    = sync_err_q;
  assign bus.Err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_tdm_demux_4to1.sv
// Bench for tdm_demux_4to1: queue-based frame model compared every cycle plus directed literal checks.
// Words are applied one clock each; outputs are observed 1 time unit after the capturing edge.
// The source never stalls except through explicit In_valid gaps.
module tb_tdm_demux_4to1;
  localparam int W  = 8;
  localparam int EW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tdm_demux_4to1_if #(.WIDTH(W), .ERR_W(EW)) bus ();

  tdm_demux_4to1 #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: words of the frame in progress, alignment flag, output images.
  logic [W-1:0]   m_q[$];
  bit             m_lock = 1'b0;
  logic [4*W-1:0] m_out = '0;
  logic [4*W-1:0] m_frame = '0;
  logic [3:0]     m_ov = '0;
  bit             m_fv = 1'b0;
  bit             m_err = 1'b0;
  int             m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is the list of words since the last marker; its length is the expected slot.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_lock = 1'b0; m_out = '0; m_frame = '0;
        m_ov = '0; m_fv = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else begin
        m_ov = '0; m_fv = 1'b0; m_err = 1'b0;
        if (bus.In_valid) begin
          if (bus.Sync) begin
            if (m_lock && m_q.size() != 0) m_err = 1'b1;
            m_q.delete();
            m_q.push_back(bus.In);
            m_lock = 1'b1;
            m_out[W-1:0] = bus.In;
            m_ov[0] = 1'b1;
          end else if (m_lock) begin
            if (m_q.size() == 0) begin
              m_err  = 1'b1;
              m_lock = 1'b0;
            end else begin
              m_out[m_q.size()*W +: W] = bus.In;
              m_ov[m_q.size()] = 1'b1;
              m_q.push_back(bus.In);
              if (m_q.size() == 4) begin
                m_frame = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_fv = 1'b1;
                m_q.delete();
              end
            end
          end
          if (m_err && m_cnt < (1 << EW) - 1) m_cnt++;
        end
      end
    end
  end

  // Every cycle, away from the rising edge, the DUT must match the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_out",       bus.Out,         m_out);
      chk("cmp_out_valid", {28'd0, bus.Out_valid}, {28'd0, m_ov});
      chk("cmp_frame",     bus.Frame,       m_frame);
      chk("cmp_frame_vld", {31'd0, bus.Frame_valid}, {31'd0, m_fv});
      chk("cmp_locked",    {31'd0, bus.Locked},      {31'd0, m_lock});
      chk("cmp_sync_err",  {31'd0, bus.Sync_err},    {31'd0, m_err});
      chk("cmp_err_cnt",   {24'd0, bus.Err_cnt},     m_cnt[31:0]);
    end
  end

  // Apply one word for exactly one rising edge, then leave the bus idle.
  task automatic send(input logic [W-1:0] w, input logic s);
    @(negedge clk);
    bus.In = w; bus.In_valid = 1'b1; bus.Sync = s;
    @(posedge clk);
    #1;
    bus.In_valid = 1'b0; bus.Sync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.In_valid = 1'b0; bus.Sync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_pulses(input string name, input logic [3:0] ov, input logic fv);
    chk({name, "_ov"}, {28'd0, bus.Out_valid}, {28'd0, ov});
    chk({name, "_fv"}, {31'd0, bus.Frame_valid}, {31'd0, fv});
  endtask

  initial begin
    bus.In = '0; bus.In_valid = 1'b0; bus.Sync = 1'b0;
    do_reset();
    #1;
    chk("rst_out",    bus.Out, 32'h0);
    chk("rst_frame",  bus.Frame, 32'h0);
    chk("rst_locked", {31'd0, bus.Locked}, 32'h0);
    chk("rst_errcnt", {24'd0, bus.Err_cnt}, 32'h0);

    // Full-rate frame.
    send(8'h11, 1'b1); chk_pulses("t1_s0", 4'b0001, 1'b0);
    chk("t1_locked", {31'd0, bus.Locked}, 32'h1);
    send(8'h22, 1'b0); chk_pulses("t1_s1", 4'b0010, 1'b0);
    send(8'h33, 1'b0); chk_pulses("t1_s2", 4'b0100, 1'b0);
    send(8'h44, 1'b0); chk_pulses("t1_s3", 4'b1000, 1'b1);
    chk("t1_frame", bus.Frame, 32'h44332211);
    chk("t1_out",   bus.Out,   32'h44332211);
    @(posedge clk); #1;
    chk_pulses("t1_after", 4'b0000, 1'b0);

    // Same frame with a 3-cycle gap between slot 1 and slot 2.
    send(8'h11, 1'b1); chk_pulses("t2_s0", 4'b0001, 1'b0);
    send(8'h22, 1'b0); chk_pulses("t2_s1", 4'b0010, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk_pulses("t2_gap", 4'b0000, 1'b0);
    end
    send(8'h33, 1'b0); chk_pulses("t2_s2", 4'b0100, 1'b0);
    send(8'h44, 1'b0); chk_pulses("t2_s3", 4'b1000, 1'b1);
    chk("t2_frame", bus.Frame, 32'h44332211);

    // Hunting: unmarked words are ignored without error.
    do_reset();
    send(8'hAA, 1'b0); chk_pulses("t3_aa", 4'b0000, 1'b0);
    chk("t3_aa_err", {31'd0, bus.Sync_err}, 32'h0);
    send(8'hBB, 1'b0); chk_pulses("t3_bb", 4'b0000, 1'b0);
    chk("t3_bb_lock", {31'd0, bus.Locked}, 32'h0);
    send(8'h01, 1'b1);
    chk("t3_out0",   {24'd0, bus.Out[7:0]}, 32'h01);
    chk("t3_locked", {31'd0, bus.Locked}, 32'h1);
    send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t3_frame", bus.Frame, 32'h04030201);

    // Early marker at slot 2 restarts the frame.
    send(8'h10, 1'b1); send(8'h20, 1'b0);
    send(8'h55, 1'b1);
    chk("t4_err",    {31'd0, bus.Sync_err}, 32'h1);
    chk("t4_errcnt", {24'd0, bus.Err_cnt}, 32'h1);
    chk_pulses("t4_restart", 4'b0001, 1'b0);
    chk("t4_out0",   {24'd0, bus.Out[7:0]}, 32'h55);
    send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    chk("t4_frame_vld", {31'd0, bus.Frame_valid}, 32'h1);
    chk("t4_frame", bus.Frame, 32'h88776655);

    // Missing marker at slot 0 drops lock.
    send(8'h99, 1'b0);
    chk("t5_err",    {31'd0, bus.Sync_err}, 32'h1);
    chk("t5_errcnt", {24'd0, bus.Err_cnt}, 32'h2);
    chk_pulses("t5_drop", 4'b0000, 1'b0);
    chk("t5_locked", {31'd0, bus.Locked}, 32'h0);

    // Drive the counter well past saturation.
    for (int i = 0; i < 260; i++) begin
      send(8'hA0, 1'b1); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
      send(8'hA4, 1'b0);
    end
    chk("t6_sat", {24'd0, bus.Err_cnt}, 32'hFF);

    // Reset mid-frame clears outputs before any clock edge.
    send(8'hC0, 1'b1); send(8'hC1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_out",    bus.Out, 32'h0);
    chk("t6_arst_frame",  bus.Frame, 32'h0);
    chk("t6_arst_ov",     {28'd0, bus.Out_valid}, 32'h0);
    chk("t6_arst_locked", {31'd0, bus.Locked}, 32'h0);
    chk("t6_arst_errcnt", {24'd0, bus.Err_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'hC2, 1'b0);
    chk_pulses("t6_needsync", 4'b0000, 1'b0);
    chk("t6_unlocked", {31'd0, bus.Locked}, 32'h0);
    send(8'hD0, 1'b1);
    chk("t6_relock", {31'd0, bus.Locked}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux_4to1.md
Name: tdm_demux_4to1

Overview:
- Sequential 1-to-4 time-division demultiplexer; the receive-side counterpart of the team's 4-to-1 mux datapath.
- Takes a single word stream, where frames of four words are marked by a frame-sync on slot 0.
- Routes each word to its channel output, publishes a complete 4-word frame snapshot, and tracks frame alignment (hunt/lock) with error reporting.

Parameters:
- WIDTH, 8, bit width of each data word/channel.
- ERR_W, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- In  input  WIDTH  multiplexed data word.
- In_valid  input  1  In carries a word this cycle.
- Sync  input  1  frame marker; meaningful only with In_valid; marks slot 0.
- Out  output  4*WIDTH  per-channel registers; channel k at bits [k*WIDTH +: WIDTH].
- Out_valid  output  4  one-cycle pulse; bit k set when channel k updated.
- Frame  output  4*WIDTH  frame snapshot; slot k at [k*WIDTH +: WIDTH].
- Frame_valid  output  1  one-cycle pulse; Frame holds a new complete frame.
- Locked  output  1  high in LOCK state.
- Sync_err  output  1  one-cycle pulse on each alignment error.
- Err_cnt  output  ERR_W  saturating count of Sync_err pulses.

Behaviour:
- Reset (async assert, sync release): state HUNT; slot counter 0; Out, Frame, Out_valid, Frame_valid, Locked, Sync_err, Err_cnt all 0; internal frame buffer 0.
- Accepted word: In_valid=1 on a rising edge. In_valid=0 cycles are gaps; they hold all state and produce no pulses. Gaps of any length are allowed, including inside a frame.
- HUNT state:
  - Words without Sync are discarded silently; no Sync_err.
  - Word with Sync: store in slot 0, slot counter becomes 1, go to LOCK.
  - Out[0] updates and Out_valid[0] pulses on the cycle after acceptance.
- LOCK state, expected slot s in 0..3:
  - Normal case: a word with (s==0 and Sync=1) or (s!=0 and Sync=0) is stored in slot s and written to Out channel s. Out_valid[s] pulses next cycle. s advances modulo 4 (3 wraps to 0).
  - Frame completion: on accepting slot 3, the next cycle Frame loads all four buffered slots and Frame_valid pulses. This occurs in the same cycle as Out_valid[3]. The Frame contents are the slot 0..3 words of that frame.
  - Early sync (s!=0, Sync=1):
    - Sync_err pulses; partial frame abandoned; no Frame_valid.
    - The word is treated as slot 0 of a new frame: Out[0] updates, Out_valid[0] pulses, s becomes 1.
    - State stays LOCK.
  - Missing sync (s==0, Sync=0): Sync_err pulses; word discarded; no Out_valid; go to HUNT with Locked deasserting next cycle.
- Err_cnt increments on each Sync_err and saturates at 2^ERR_W-1; cleared only by reset.
- Latency: one clock from accepted word to Out/Out_valid; one clock from slot-3 acceptance to Frame_valid.
- Out channels not written hold their previous values. Frame holds its value until the next complete frame.
- Back-to-back frames at full rate (In_valid held 1) yield Frame_valid once every 4 cycles.
- Reset asserted mid-frame immediately returns to the reset state. The partial frame is lost, and the next frame requires Sync.

Test Plan:
- Reset then words A0(Sync),A1,A2,A3 with WIDTH=8, values 8'h11,8'h22,8'h33,8'h44 on consecutive cycles:
  - Out_valid = 0001,0010,0100,1000 on successive cycles.
  - Frame=32'h44332211 with a single Frame_valid pulse aligned with Out_valid[3].
  - Locked=1.
- Same frame with a 3-cycle In_valid gap between slot 1 and slot 2: identical outputs, shifted by the gap; no pulses during the gap.
- In HUNT, feed 8'hAA,8'hBB without Sync: no Out_valid, no Sync_err, Locked=0. Then 8'h01 with Sync: Out[7:0]=8'h01, Locked=1.
- In LOCK, send slot0(Sync),slot1, then 8'h55 with Sync at s=2:
  - Sync_err pulse; Err_cnt=1; no Frame_valid.
  - Out[7:0]=8'h55; the next three words complete a frame whose slot 0 is 8'h55.
- After a complete frame, send a word at s=0 without Sync: Sync_err pulse, Err_cnt increments, no Out_valid, Locked=0 next cycle.
- Force 260 missing-sync errors with ERR_W=8: Err_cnt saturates at 255. Then assert rst_n=0 mid-frame: all outputs are 0 asynchronously, before the next clock edge.
